// File: rtl/and_operand_feeder.sv
// Operand-pair FIFO feeding an external combinational AND stage. Each pair is
// issued with a one-cycle enable, and its result is returned on a valid/ready stream.
module and_operand_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_in1,
  input  logic [WIDTH-1:0]         s_in2,
  output logic [WIDTH-1:0]         and_in1,
  output logic [WIDTH-1:0]         and_in2,
  output logic                     and_enable,
  input  logic [WIDTH-1:0]         and_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [2*WIDTH-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic                   push_s;
  logic                   pop_s;
  logic                   hs_s;
  logic [WIDTH-1:0]       and_in1_r;
  logic [WIDTH-1:0]       and_in2_r;
  logic                   and_enable_r;
  logic                   m_valid_r;
  logic [WIDTH-1:0]       m_data_r;

  // Full is judged on the current occupancy, so a same-cycle pop never frees a slot.
  assign s_ready    = (count_r < CNT_W'(DEPTH));
  assign push_s     = s_valid & s_ready;
  assign hs_s       = m_valid_r & m_ready;
  assign and_in1    = and_in1_r;
  assign and_in2    = and_in2_r;
  assign and_enable = and_enable_r;
  assign m_valid    = m_valid_r;
  assign m_data     = m_data_r;
  assign count      = count_r;

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sequencer next-state and pop decision.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_W'(0)) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_DRIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (hs_s) begin
          if (count_r != CNT_W'(0)) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_DRIVE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {s_in1, s_in2};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

  // Operand drive, enable pulse and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_in1_r    <= '0;
      and_in2_r    <= '0;
      and_enable_r <= 1'b0;
      m_valid_r    <= 1'b0;
      m_data_r     <= '0;
    end else begin
      and_enable_r <= pop_s;
      if (pop_s) begin
        {and_in1_r, and_in2_r} <= mem_r[rd_ptr_r];
      end
      // The AND stage is combinational, so its output is settled by the end of DRIVE.
      if (state_r == ST_DRIVE) begin
        m_data_r  <= and_out;
        m_valid_r <= 1'b1;
      end else if (hs_s) begin
        m_valid_r <= 1'b0;
      end
    end
  end

endmodule
